// File: rtl/seq_detect_mm.sv
// Parametrised serial pattern detector (KMP automaton) with registered Moore flag,
// combinational Mealy flag, overlap/non-overlap restart and a saturating match counter.
module seq_detect_mm #(
  parameter int                   PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1011,
  parameter bit                   OVERLAP = 1'b1,
  parameter int                   CNT_W   = 8,
  localparam int                  ST_W    = $clog2(PAT_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             x_valid,
  input  logic             cnt_clr,
  output logic             moore,
  output logic             mealy,
  output logic [ST_W-1:0]  CS,
  output logic [ST_W-1:0]  NS,
  output logic [CNT_W-1:0] match_cnt
);

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_MATCH = ST_W'(PAT_LEN);

  // Longest pattern prefix that is a suffix of (first s pattern bits, then b).
  // Pattern bit i of the received order is PATTERN[PAT_LEN-1-i].
  function automatic int delta_f(input int s, input logic b);
    int   best;
    int   j;
    logic ok;
    best = 0;
    for (int k = 1; k <= PAT_LEN; k++) begin
      if (k <= s + 1) begin
        ok = 1'b1;
        for (int i = 0; i < PAT_LEN; i++) begin
          if (i < k) begin
            j = s + 1 - k + i;
            if (j == s) begin
              ok = ok & (PATTERN[PAT_LEN-1-i] == b);
            end else begin
              ok = ok & (PATTERN[PAT_LEN-1-i] == PATTERN[PAT_LEN-1-j]);
            end
          end
        end
        if (ok) begin
          best = k;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           cs_q;
  state_t           ns_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  state_t           nxt0_w [PAT_LEN+1];
  state_t           nxt1_w [PAT_LEN+1];

  // Transition tables built at elaboration; non-overlap restarts from state 0 after a match.
  for (genvar g = 0; g <= PAT_LEN; g++) begin : g_tab
    localparam int S_EFF = ((g == PAT_LEN) && !OVERLAP) ? 0 : g;
    assign nxt0_w[g] = ST_W'(delta_f(S_EFF, 1'b0));
    assign nxt1_w[g] = ST_W'(delta_f(S_EFF, 1'b1));
  end

  always_comb begin
    ns_d = cs_q;
    if (x_valid) begin
      for (int s = 0; s <= PAT_LEN; s++) begin
        if (cs_q == ST_W'(s)) begin
          ns_d = x ? nxt1_w[s] : nxt0_w[s];
        end
      end
    end
  end

  assign mealy = x_valid & (ns_d == ST_MATCH) & ~reset;
  assign moore = (cs_q == ST_MATCH);

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = mealy ? CNT_W'(1) : '0;
    end else if (mealy) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q  <= '0;
      cnt_q <= '0;
    end else begin
      cs_q  <= ns_d;
      cnt_q <= cnt_d;
    end
  end

  assign CS        = cs_q;
  assign NS        = ns_d;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_mm.sv
// Directed bench for seq_detect_mm: default overlapping detector, a non-overlapping
// copy and a 2-bit-counter copy all driven from the same serial stream.
module tb_seq_detect_mm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       x = 1'b0;
  logic       x_valid = 1'b0;
  logic       cnt_clr = 1'b0;

  logic       moore_d, mealy_d, moore_n, mealy_n, moore_s, mealy_s;
  logic [2:0] cs_d, ns_d, cs_n, ns_n, cs_s, ns_s;
  logic [7:0] cnt_d, cnt_n;
  logic [1:0] cnt_s;

  logic       m_d, m_n, m_s;
  logic [2:0] nsamp_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_mm u_dut (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cnt_clr(cnt_clr),
    .moore(moore_d), .mealy(mealy_d), .CS(cs_d), .NS(ns_d), .match_cnt(cnt_d)
  );

  seq_detect_mm #(.OVERLAP(1'b0)) u_nov (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cnt_clr(cnt_clr),
    .moore(moore_n), .mealy(mealy_n), .CS(cs_n), .NS(ns_n), .match_cnt(cnt_n)
  );

  seq_detect_mm #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cnt_clr(cnt_clr),
    .moore(moore_s), .mealy(mealy_s), .CS(cs_s), .NS(ns_s), .match_cnt(cnt_s)
  );

  // Drive one cycle of inputs, capture the combinational flags before the edge,
  // then return #1 after the edge so registered outputs can be sampled.
  task automatic send_bit(input logic b, input logic v, input logic clr, input logic rst);
    x       = b;
    x_valid = v;
    cnt_clr = clr;
    reset   = rst;
    #1;
    m_d     = mealy_d;
    m_n     = mealy_n;
    m_s     = mealy_s;
    nsamp_d = ns_d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    send_bit(1'b0, 1'b0, 1'b0, 1'b1);
    send_bit(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    x = 1'b1;
    x_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cs_d !== 3'd0) begin errors++; $display("FAIL reset_cs got %0d exp 0", cs_d); end
    checks++;
    if (moore_d !== 1'b0) begin errors++; $display("FAIL reset_moore got %0b exp 0", moore_d); end
    checks++;
    if (mealy_d !== 1'b0) begin errors++; $display("FAIL reset_mealy got %0b exp 0", mealy_d); end
    checks++;
    if (cnt_d !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt_d); end
    x_valid = 1'b0;
    x = 1'b0;
  endtask

  task automatic test_overlap();
    logic       bits   [7] = '{1, 0, 1, 1, 0, 1, 1};
    logic [2:0] exp_cs [7] = '{1, 2, 3, 4, 2, 3, 4};
    logic       exp_me [7] = '{0, 0, 0, 1, 0, 0, 1};
    logic [2:0] exp_nc [7] = '{1, 2, 3, 4, 0, 1, 1};
    logic       exp_nm [7] = '{0, 0, 0, 1, 0, 0, 0};
    logic       exp_mo;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      send_bit(bits[i], 1'b1, 1'b0, 1'b0);
      exp_mo = (i == 3) || (i == 6);
      checks++;
      if (m_d !== exp_me[i]) begin errors++; $display("FAIL ovl_mealy bit%0d got %0b exp %0b", i + 1, m_d, exp_me[i]); end
      checks++;
      if (cs_d !== exp_cs[i]) begin errors++; $display("FAIL ovl_cs bit%0d got %0d exp %0d", i + 1, cs_d, exp_cs[i]); end
      checks++;
      if (moore_d !== exp_mo) begin errors++; $display("FAIL ovl_moore bit%0d got %0b exp %0b", i + 1, moore_d, exp_mo); end
      checks++;
      if (m_n !== exp_nm[i]) begin errors++; $display("FAIL nov_mealy bit%0d got %0b exp %0b", i + 1, m_n, exp_nm[i]); end
      checks++;
      if (cs_n !== exp_nc[i]) begin errors++; $display("FAIL nov_cs bit%0d got %0d exp %0d", i + 1, cs_n, exp_nc[i]); end
    end
    checks++;
    if (cnt_d !== 8'd2) begin errors++; $display("FAIL ovl_cnt got %0d exp 2", cnt_d); end
    checks++;
    if (cnt_n !== 8'd1) begin errors++; $display("FAIL nov_cnt got %0d exp 1", cnt_n); end
    send_bit(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (moore_d !== 1'b1) begin errors++; $display("FAIL ovl_moore_hold got %0b exp 1", moore_d); end
  endtask

  task automatic test_valid_gap();
    logic gapx [3] = '{1, 0, 1};
    do_reset();
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_bit(gapx[i], 1'b0, 1'b0, 1'b0);
      checks++;
      if (m_d !== 1'b0) begin errors++; $display("FAIL gap_mealy cyc%0d got %0b exp 0", i, m_d); end
      checks++;
      if (nsamp_d !== 3'd3) begin errors++; $display("FAIL gap_ns cyc%0d got %0d exp 3", i, nsamp_d); end
      checks++;
      if (cs_d !== 3'd3) begin errors++; $display("FAIL gap_cs cyc%0d got %0d exp 3", i, cs_d); end
    end
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (m_d !== 1'b1) begin errors++; $display("FAIL gap_final_mealy got %0b exp 1", m_d); end
    checks++;
    if (cs_d !== 3'd4) begin errors++; $display("FAIL gap_final_cs got %0d exp 4", cs_d); end
    checks++;
    if (cnt_d !== 8'd1) begin errors++; $display("FAIL gap_cnt got %0d exp 1", cnt_d); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_s;
    do_reset();
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (cnt_s !== 2'd1) begin errors++; $display("FAIL sat_cnt match1 got %0d exp 1", cnt_s); end
    for (int k = 2; k <= 6; k++) begin
      send_bit(1'b0, 1'b1, 1'b0, 1'b0);
      send_bit(1'b1, 1'b1, 1'b0, 1'b0);
      send_bit(1'b1, 1'b1, 1'b0, 1'b0);
      exp_s = (k >= 3) ? 2'd3 : 2'(k);
      checks++;
      if (m_s !== 1'b1) begin errors++; $display("FAIL sat_mealy match%0d got %0b exp 1", k, m_s); end
      checks++;
      if (cnt_s !== exp_s) begin errors++; $display("FAIL sat_cnt match%0d got %0d exp %0d", k, cnt_s, exp_s); end
    end
    checks++;
    if (cnt_d !== 8'd6) begin errors++; $display("FAIL b2b_cnt got %0d exp 6", cnt_d); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    // The completing bit arrives during reset: no pulse, no count, progress lost.
    send_bit(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (m_d !== 1'b0) begin errors++; $display("FAIL rstmid_mealy got %0b exp 0", m_d); end
    checks++;
    if (cs_d !== 3'd0) begin errors++; $display("FAIL rstmid_cs got %0d exp 0", cs_d); end
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (m_d !== 1'b0) begin errors++; $display("FAIL rstmid_after_mealy got %0b exp 0", m_d); end
    checks++;
    if (cs_d !== 3'd1) begin errors++; $display("FAIL rstmid_after_cs got %0d exp 1", cs_d); end
    checks++;
    if (cnt_d !== 8'd0) begin errors++; $display("FAIL rstmid_cnt got %0d exp 0", cnt_d); end
  endtask

  task automatic test_cnt_clr();
    do_reset();
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      send_bit(1'b0, 1'b1, 1'b0, 1'b0);
      send_bit(1'b1, 1'b1, 1'b0, 1'b0);
      send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    end
    checks++;
    if (cnt_d !== 8'd5) begin errors++; $display("FAIL clr_pre_cnt got %0d exp 5", cnt_d); end
    send_bit(1'b0, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (m_d !== 1'b1) begin errors++; $display("FAIL clr_match_mealy got %0b exp 1", m_d); end
    checks++;
    if (cnt_d !== 8'd1) begin errors++; $display("FAIL clr_match_cnt got %0d exp 1", cnt_d); end
    checks++;
    if (cnt_s !== 2'd1) begin errors++; $display("FAIL clr_match_sat got %0d exp 1", cnt_s); end
    send_bit(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (cnt_d !== 8'd0) begin errors++; $display("FAIL clr_alone_cnt got %0d exp 0", cnt_d); end
    checks++;
    if (cs_d !== 3'd4) begin errors++; $display("FAIL clr_alone_cs got %0d exp 4", cs_d); end
    send_bit(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_valid_gap();
    test_back_to_back();
    test_reset_mid();
    test_cnt_clr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
